// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: state encoding,
// CSR addresses, cause codes, mstatus bit positions and mstatus update helpers.
package trap_ctrl_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned MEM_ADDR_WIDTH = 32;

   localparam logic [MEM_ADDR_WIDTH-1:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [MEM_ADDR_WIDTH-1:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [MEM_ADDR_WIDTH-1:0] CSR_MCAUSE  = 32'h0000_0342;

   localparam logic [2:0] S_IDLE          = 3'd0;
   localparam logic [2:0] S_W_MEPC        = 3'd1;
   localparam logic [2:0] S_W_MCAUSE      = 3'd2;
   localparam logic [2:0] S_W_MSTATUS     = 3'd3;
   localparam logic [2:0] S_W_MSTATUS_RET = 3'd4;
   localparam logic [2:0] S_JUMP          = 3'd5;

   localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL     = 32'd11;
   localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK    = 32'd3;
   localparam logic [DATA_WIDTH-1:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   // Trap entry: stash MIE into MPIE and disable interrupts.
   function automatic logic [DATA_WIDTH-1:0] mstatus_enter(input logic [DATA_WIDTH-1:0] ms);
      logic [DATA_WIDTH-1:0] r;
      r               = ms;
      r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // Trap return: restore MIE from MPIE and set MPIE.
   function automatic logic [DATA_WIDTH-1:0] mstatus_leave(input logic [DATA_WIDTH-1:0] ms);
      logic [DATA_WIDTH-1:0] r;
      r               = ms;
      r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects ecall/ebreak/mret/timer irq, stalls the
// pipeline, writes mepc/mcause/mstatus one per cycle, then pulses a redirect.
// TRAP_CTRL_IRQ_LATCH_EN: when defined, a rising irq_i is latched as pending
// until taken; otherwise irq_i is a level request sampled only in IDLE.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] IRQ_CAUSE = CAUSE_TIMER_IRQ
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     inst_addr_i,
   input  logic                      ecall_i,
   input  logic                      ebreak_i,
   input  logic                      mret_i,
   input  logic                      jump_flag_i,
   input  logic [DATA_WIDTH-1:0]     jump_addr_i,
   input  logic                      irq_i,
   input  logic                      ex_csr_we_i,
   input  logic                      global_int_en_i,
   input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
   input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
   input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
   output logic                      csr_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] csr_waddr_o,
   output logic [DATA_WIDTH-1:0]     csr_wdata_o,
   output logic                      hold_o,
   output logic                      int_assert_o,
   output logic [DATA_WIDTH-1:0]     int_addr_o
);

   logic [2:0]                state;
   logic [2:0]                state_next;
   logic [DATA_WIDTH-1:0]     epc;
   logic [DATA_WIDTH-1:0]     epc_next;
   logic [DATA_WIDTH-1:0]     cause;
   logic [DATA_WIDTH-1:0]     cause_next;
   logic [DATA_WIDTH-1:0]     target;
   logic [DATA_WIDTH-1:0]     target_next;
   logic                      we_next;
   logic [MEM_ADDR_WIDTH-1:0] waddr_next;
   logic [DATA_WIDTH-1:0]     wdata_next;
   logic                      assert_next;
   logic [DATA_WIDTH-1:0]     addr_next;
   logic                      accept_c;
   logic                      clear_pend_c;
   logic                      irq_pend;

`ifdef TRAP_CTRL_IRQ_LATCH_EN
   logic irq_prev;

   // Latch a rising irq edge until the interrupt is taken; a new edge wins over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev <= 1'b0;
         irq_pend <= 1'b0;
      end else begin
         irq_prev <= irq_i;
         irq_pend <= (irq_pend & ~clear_pend_c) | (irq_i & ~irq_prev);
      end
   end
`else
   assign irq_pend = irq_i;
`endif

   // Next state, capture values and the registered write-port / redirect values.
   always_comb begin
      state_next   = state;
      epc_next     = epc;
      cause_next   = cause;
      target_next  = target;
      we_next      = 1'b0;
      waddr_next   = '0;
      wdata_next   = '0;
      assert_next  = 1'b0;
      addr_next    = '0;
      accept_c     = 1'b0;
      clear_pend_c = 1'b0;

      case (state)
         S_IDLE: begin
            // Ex CSR writes take precedence in the CSR file, so hold off any event.
            if (!ex_csr_we_i) begin
               if (ecall_i || ebreak_i) begin
                  accept_c   = 1'b1;
                  epc_next   = inst_addr_i;
                  cause_next = ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
                  state_next = S_W_MEPC;
                  we_next    = 1'b1;
                  waddr_next = CSR_MEPC;
                  wdata_next = inst_addr_i;
               end else if (mret_i) begin
                  accept_c   = 1'b1;
                  state_next = S_W_MSTATUS_RET;
                  we_next    = 1'b1;
                  waddr_next = CSR_MSTATUS;
                  wdata_next = mstatus_leave(csr_mstatus_i);
               end else if (irq_pend && global_int_en_i) begin
                  accept_c     = 1'b1;
                  clear_pend_c = 1'b1;
                  epc_next     = jump_flag_i ? jump_addr_i : DATA_WIDTH'(inst_addr_i + 32'd4);
                  cause_next   = IRQ_CAUSE;
                  state_next   = S_W_MEPC;
                  we_next      = 1'b1;
                  waddr_next   = CSR_MEPC;
                  wdata_next   = epc_next;
               end
            end
         end
         S_W_MEPC: begin
            state_next = S_W_MCAUSE;
            we_next    = 1'b1;
            waddr_next = CSR_MCAUSE;
            wdata_next = cause;
         end
         S_W_MCAUSE: begin
            state_next = S_W_MSTATUS;
            we_next    = 1'b1;
            waddr_next = CSR_MSTATUS;
            wdata_next = mstatus_enter(csr_mstatus_i);
         end
         S_W_MSTATUS: begin
            state_next  = S_JUMP;
            target_next = csr_mtvec_i;
            assert_next = 1'b1;
            addr_next   = csr_mtvec_i;
         end
         S_W_MSTATUS_RET: begin
            state_next  = S_JUMP;
            target_next = csr_mepc_i;
            assert_next = 1'b1;
            addr_next   = csr_mepc_i;
         end
         S_JUMP: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Stall from the detection cycle through the redirect cycle.
   assign hold_o = (state != S_IDLE) | accept_c;

   // State, capture and output registers; reset abandons any sequence in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         epc          <= '0;
         cause        <= '0;
         target       <= '0;
         csr_we_o     <= 1'b0;
         csr_waddr_o  <= '0;
         csr_wdata_o  <= '0;
         int_assert_o <= 1'b0;
         int_addr_o   <= '0;
      end else begin
         state        <= state_next;
         epc          <= epc_next;
         cause        <= cause_next;
         target       <= target_next;
         csr_we_o     <= we_next;
         csr_waddr_o  <= waddr_next;
         csr_wdata_o  <= wdata_next;
         int_assert_o <= assert_next;
         int_addr_o   <= addr_next;
      end
   end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the core. It detects synchronous exceptions (ecall, ebreak), `mret` and the external timer interrupt. It stalls the pipeline while it works and sequences the required CSR updates one per cycle through the CSR file's clint write port: mepc, then mcause, then mstatus. It then issues a single redirect pulse to the fetch stage, with the target taken from mtvec or mepc.

## Interface
Parameters:
- `IRQ_CAUSE`, default 32'h8000_0007: mcause value written for the timer interrupt.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `inst_addr_i` in `DATA_WIDTH`: PC of the instruction in ex.
- `ecall_i`, `ebreak_i`, `mret_i` in 1 each: decode flags from ex.
- `jump_flag_i` in 1, `jump_addr_i` in `DATA_WIDTH`: ex branch/jump taken this cycle, and its target.
- `irq_i` in 1: timer interrupt request.
- `ex_csr_we_i` in 1: ex is writing a CSR this cycle.
- `global_int_en_i` in 1: mstatus.MIE from the CSR file.
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i` in `DATA_WIDTH`: direct CSR values.
- `csr_we_o` out 1, `csr_waddr_o` out `MemAddrWIDTH`, `csr_wdata_o` out `DATA_WIDTH`: clint CSR write port.
- `hold_o` out 1: pipeline stall request.
- `int_assert_o` out 1, `int_addr_o` out `DATA_WIDTH`: one-cycle redirect pulse and its target.

## Operation
- **States:** IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MSTATUS_RET, JUMP.
- **Event priority in IDLE:** ecall/ebreak first, then mret, then interrupt.
- **Interrupt eligibility:** an interrupt is eligible only when `irq_pend && global_int_en_i`.
- **Deferral on ex CSR write:** any event is deferred while `ex_csr_we_i=1`, because ex writes win in the CSR file. The event flags must be held by the stalled pipeline.
- **Exception entry:**
  - Capture epc = `inst_addr_i`.
  - Capture cause = 11 for ecall, 3 for ebreak.
  - Next state W_MEPC.
- **Interrupt entry:**
  - Capture epc = `jump_flag_i ? jump_addr_i : inst_addr_i+4`.
  - Capture cause = `IRQ_CAUSE`.
  - Clear pending.
  - Next state W_MEPC.
- **W_MEPC:** write mepc = epc, then go to W_MCAUSE.
- **W_MCAUSE:** write mcause = cause, then go to W_MSTATUS.
- **W_MSTATUS:** write `csr_mstatus_i` with bit7 (MPIE) set to bit3, and bit3 (MIE) set to 0. Then go to JUMP with target `csr_mtvec_i`.
- **mret:**
  - IDLE goes to W_MSTATUS_RET.
  - W_MSTATUS_RET writes mstatus with bit3 set to bit7 and bit7 set to 1. Then go to JUMP with target `csr_mepc_i`.
- **JUMP:** `int_assert_o=1` and `int_addr_o` = captured target, then return to IDLE.
- **Write port:** `csr_we_o` is high only in the W_* states; `csr_waddr_o` holds the matching `CSR_*` address.
- **`hold_o`:** `hold_o` = `(state!=IDLE) | accepted_event`, combinational. The pipeline therefore freezes in the detection cycle.
- **Arithmetic:** all arithmetic is `DATA_WIDTH`, wrapping; `inst_addr_i+4` at 32'hFFFF_FFFC wraps to 0.

## Timing
- **Exception or interrupt detected in cycle T:**
  - mepc written at T+1.
  - mcause written at T+2.
  - mstatus written at T+3.
  - `int_assert_o` at T+4.
  - IDLE at T+5.
  - `hold_o` is high T..T+4.
- **mret at T:** mstatus written at T+1, `int_assert_o` at T+2, `hold_o` high T..T+2.
- **Events arriving outside IDLE:** ignored, except `irq_i`, which is handled per Configuration.
- **Reset values:** all outputs 0. State IDLE; epc, cause and target are 0; pending is 0.
- **Reset mid-sequence:** return to IDLE immediately. Remaining CSR writes are not performed and no redirect is issued.

## Configuration
- **`TRAP_CTRL_IRQ_LATCH_EN` defined:**
  - A rising `irq_i` sets `irq_pend`, which stays set until the interrupt is taken.
  - The interrupt may therefore be a single-cycle pulse, and it survives periods when MIE=0 or the controller is busy.
- **`TRAP_CTRL_IRQ_LATCH_EN` undefined:** `irq_pend = irq_i`, i.e. a level request sampled only in IDLE.

## Structure
- **Shared package / include:**
  - state encoding;
  - cause codes (11, 3, 32'h8000_0007);
  - mstatus bit indices MIE=3 and MPIE=7;
  - reuse of the existing `CSR_MEPC`, `CSR_MCAUSE`, `CSR_MSTATUS`, `DATA_WIDTH` and `MemAddrWIDTH` defines.
- **Sub-modules:** none. One flat FSM plus capture registers is natural. The pending latch is a few lines and does not merit a sub-module.

## Test plan
- **ecall:** ecall at PC 0x100 with mtvec=0x200 and mstatus=0x8 → mepc=0x100 at T+1, mcause=11 at T+2, mstatus=0x80 at T+3, `int_assert_o` with addr 0x200 at T+4, `hold_o` high 5 cycles.
- **mret:** mret with mepc=0x104 and mstatus=0x80 → mstatus=0x88 at T+1, redirect to 0x104 at T+2.
- **Interrupt:** irq pulse with MIE=0 is not taken. Setting MIE=1, with the macro defined, takes it; with jump_flag=1 and jump_addr=0x300, mepc=0x300 and mcause=0x8000_0007.
- **Simultaneous events:** ecall and irq in the same cycle → ecall sequence runs. The interrupt stays pending (macro defined) and is taken after mret restores MIE.
- **Collision deferral:** ecall with `ex_csr_we_i=1` → no `csr_we_o` that cycle; the sequence starts the cycle `ex_csr_we_i` drops.
- **Reset mid-sequence:** `rst` asserted in W_MCAUSE → all outputs 0 immediately. No mstatus write and no redirect follow after release.
